// File: rtl/atm_bank_responder.sv
// rtl/atm_bank_responder.sv - bank-side responder owning balance, PIN retries, auth and mini statement
// One request in, one response out per transaction over valid/ready handshakes.
module atm_bank_responder #(
    parameter logic [15:0] INIT_BALANCE = 16'd1000,
    parameter logic [3:0]  PIN_CODE     = 4'd0,
    parameter logic [15:0] OTP_CODE     = 16'h1234,
    parameter int          MAX_TRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        session_end,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_pin,
    input  logic [15:0] req_otp,
    input  logic [15:0] req_amount,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_status,
    output logic [15:0] rsp_balance,
    output logic        account_blocked,
    output logic [15:0] mini_statement
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_BAD_PIN      = 3'd1;
    localparam logic [2:0] ST_BLOCKED      = 3'd2;
    localparam logic [2:0] ST_BAD_OTP      = 3'd3;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
    localparam logic [2:0] ST_OVERFLOW     = 3'd5;
    localparam logic [2:0] ST_NOT_AUTH     = 3'd6;
    localparam logic [2:0] MAX_CNT         = 3'(MAX_TRIES);

    state_t      state, next_state;
    logic [1:0]  op_q;
    logic [3:0]  pin_q;
    logic [15:0] otp_q;
    logic [15:0] amount_q;
    logic [15:0] balance;
    logic [2:0]  fail_cnt;
    logic        auth;
    logic        blocked;

    logic [2:0]  ev_status;
    logic [15:0] ev_balance;
    logic        pin_match;
    logic        pin_bad;
    logic        auth_eff;
    logic [16:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) next_state = EXEC;
            end
            EXEC: next_state = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A session_end landing in the evaluation cycle revokes auth for that request.
    always_comb begin
        auth_eff   = auth & ~session_end;
        sum        = {1'b0, balance} + {1'b0, amount_q};
        ev_status  = ST_OK;
        ev_balance = balance;
        pin_match  = 1'b0;
        pin_bad    = 1'b0;
        if (blocked) begin
            ev_status = ST_BLOCKED;
        end else if (op_q == 2'b00) begin
            if (pin_q == PIN_CODE) begin
                pin_match = 1'b1;
            end else begin
                pin_bad   = 1'b1;
                ev_status = ST_BAD_PIN;
            end
        end else if (!auth_eff) begin
            ev_status = ST_NOT_AUTH;
        end else begin
            case (op_q)
                2'b01: begin
                    if (otp_q != OTP_CODE) begin
                        ev_status = ST_BAD_OTP;
                    end else if (amount_q > balance) begin
                        ev_status = ST_INSUFFICIENT;
                    end else begin
                        ev_balance = balance - amount_q;
                    end
                end
                2'b10: begin
                    if (sum[16]) begin
                        ev_status = ST_OVERFLOW;
                    end else begin
                        ev_balance = sum[15:0];
                    end
                end
                default: ev_status = ST_OK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q           <= 2'b00;
            pin_q          <= 4'd0;
            otp_q          <= 16'd0;
            amount_q       <= 16'd0;
            balance        <= INIT_BALANCE;
            fail_cnt       <= 3'd0;
            blocked        <= 1'b0;
            rsp_status     <= 3'd0;
            rsp_balance    <= 16'd0;
            mini_statement <= 16'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q     <= req_op;
                pin_q    <= req_pin;
                otp_q    <= req_otp;
                amount_q <= req_amount;
            end
            if (state == EXEC) begin
                balance     <= ev_balance;
                rsp_status  <= ev_status;
                rsp_balance <= ev_balance;
                if (pin_match) fail_cnt <= 3'd0;
                if (pin_bad && fail_cnt < MAX_CNT) begin
                    fail_cnt <= fail_cnt + 3'd1;
                    if (fail_cnt + 3'd1 == MAX_CNT) blocked <= 1'b1;
                end
                if (op_q != 2'b00) begin
                    mini_statement <= {mini_statement[11:0], op_q, ev_status == ST_OK, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auth <= 1'b0;
        end else if (session_end) begin
            auth <= 1'b0;
        end else if (state == EXEC && pin_match) begin
            auth <= 1'b1;
        end
    end

    assign account_blocked = blocked;

endmodule

// File: tb/tb_atm_bank_responder.sv
// tb/tb_atm_bank_responder.sv - randomized self-checking bench for atm_bank_responder
// Expected results come from a transaction-level account model kept in the bench.
module tb_atm_bank_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        session_end = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_pin = 4'd0;
    logic [15:0] req_otp = 16'd0;
    logic [15:0] req_amount = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [2:0]  rsp_status;
    logic [15:0] rsp_balance;
    logic        account_blocked;
    logic [15:0] mini_statement;

    int checks = 0;
    int errors = 0;

    int       m_bal;
    int       m_tries;
    bit       m_blocked;
    bit       m_auth;
    bit [3:0] m_log[$];

    atm_bank_responder dut (
        .clk(clk), .reset(reset), .session_end(session_end),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_pin(req_pin), .req_otp(req_otp), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_balance(rsp_balance), .account_blocked(account_blocked),
        .mini_statement(mini_statement)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_mini();
        logic [15:0] v = 16'd0;
        for (int i = 0; i < m_log.size(); i++) v = v | (16'(m_log[i]) << (4 * i));
        return v;
    endfunction

    task automatic model_reset();
        m_bal = 1000; m_tries = 0; m_blocked = 0; m_auth = 0;
        m_log.delete();
    endtask

    task automatic model_exec(input int op, input int pin, input int otp, input int amt,
                              input bit se, output int st);
        bit was_blocked = m_blocked;
        bit pin_ok = 0;
        if (m_blocked) st = 2;
        else if (op == 0) begin
            if (pin == 0) begin st = 0; m_tries = 0; pin_ok = 1; end
            else begin
                st = 1;
                if (m_tries < 3) m_tries++;
                if (m_tries == 3) m_blocked = 1;
            end
        end else if (!(m_auth && !se)) st = 6;
        else if (op == 1) begin
            if (otp != 'h1234) st = 3;
            else if (amt > m_bal) st = 4;
            else begin st = 0; m_bal = m_bal - amt; end
        end else if (op == 2) begin
            if (m_bal + amt > 65535) st = 5;
            else begin st = 0; m_bal = m_bal + amt; end
        end else st = 0;
        if (op != 0) begin
            m_log.push_front(4'((op << 2) | ((st == 0) ? 2 : 0) | 1));
            if (m_log.size() > 4) void'(m_log.pop_back());
        end
        if (se) m_auth = 0;
        else if (!was_blocked && pin_ok) m_auth = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        session_end = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_txn(input string name, input int op, input int pin, input int otp,
                          input int amt, input bit se);
        int st;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'(op); req_pin = 4'(pin);
        req_otp = 16'(otp); req_amount = 16'(amt);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL %s req_ready timeout: got %0b want 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (se) begin
            session_end = 1'b1;
            @(posedge clk); #1;
            session_end = 1'b0;
        end
        model_exec(op, pin, otp, amt, se, st);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL %s rsp_valid timeout: got %0b want 1", name, rsp_valid);
            return;
        end
        checks += 4;
        if (rsp_status !== 3'(st)) begin
            errors++;
            $display("FAIL %s status: got %0d want %0d", name, rsp_status, st);
        end
        if (rsp_balance !== 16'(m_bal)) begin
            errors++;
            $display("FAIL %s balance: got %0d want %0d", name, rsp_balance, m_bal);
        end
        if (account_blocked !== m_blocked) begin
            errors++;
            $display("FAIL %s blocked: got %0b want %0b", name, account_blocked, m_blocked);
        end
        if (mini_statement !== model_mini()) begin
            errors++;
            $display("FAIL %s mini: got %h want %h", name, mini_statement, model_mini());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        checks += 6;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset req_ready: got %0b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %0b want 0", rsp_valid); end
        if (rsp_status !== 3'd0) begin errors++; $display("FAIL reset rsp_status: got %0d want 0", rsp_status); end
        if (rsp_balance !== 16'd0) begin errors++; $display("FAIL reset rsp_balance: got %0d want 0", rsp_balance); end
        if (account_blocked !== 1'b0) begin errors++; $display("FAIL reset blocked: got %0b want 0", account_blocked); end
        if (mini_statement !== 16'd0) begin errors++; $display("FAIL reset mini: got %h want 0", mini_statement); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset req_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_withdraw();
        do_txn("pin_ok", 0, 0, 0, 0, 0);
        do_txn("withdraw_500", 1, 0, 'h1234, 500, 0);
        checks++;
        if (mini_statement[3:0] !== 4'b0111) begin
            errors++;
            $display("FAIL withdraw_entry: got %b want 0111", mini_statement[3:0]);
        end
        do_reset();
        do_txn("pin_ok2", 0, 0, 0, 0, 0);
        do_txn("bad_otp", 1, 0, 'h1111, 500, 0);
        do_txn("withdraw_zero", 1, 0, 'h1234, 0, 0);
        do_txn("insufficient", 1, 0, 'h1234, 1001, 0);
        do_txn("withdraw_all", 1, 0, 'h1234, 1000, 0);
    endtask

    task automatic test_block();
        do_reset();
        do_txn("bad_pin1", 0, 5, 0, 0, 0);
        do_txn("bad_pin2", 0, 5, 0, 0, 0);
        do_txn("bad_pin3", 0, 5, 0, 0, 0);
        do_txn("pin_when_blocked", 0, 0, 0, 0, 0);
        do_txn("enquiry_when_blocked", 3, 0, 0, 0, 0);
    endtask

    task automatic test_deposit();
        do_reset();
        do_txn("deposit_noauth", 2, 0, 0, 200, 0);
        do_txn("pin_ok3", 0, 0, 0, 0, 0);
        do_txn("deposit_200", 2, 0, 0, 200, 0);
        do_txn("deposit_ffff", 2, 0, 0, 'hFFFF, 0);
        do_txn("deposit_zero", 2, 0, 0, 0, 0);
        do_txn("deposit_to_max", 2, 0, 0, 65535 - 1200, 0);
        do_txn("enquiry", 3, 0, 0, 0, 0);
    endtask

    task automatic test_session_end();
        do_reset();
        do_txn("pin_ok4", 0, 0, 0, 0, 0);
        do_txn("insufficient_1001", 1, 0, 'h1234, 1001, 0);
        @(negedge clk); session_end = 1'b1;
        @(negedge clk); session_end = 1'b0;
        m_auth = 0;
        do_txn("enquiry_after_end", 3, 0, 0, 0, 0);
        do_txn("pin_with_end_in_exec", 0, 0, 0, 0, 1);
        do_txn("enquiry_after_exec_end", 3, 0, 0, 0, 0);
        do_txn("pin_ok5", 0, 0, 0, 0, 0);
        do_txn("deposit_with_end_in_exec", 2, 0, 0, 10, 1);
    endtask

    task automatic test_random();
        int op, pin, otp, amt, sel;
        bit se;
        do_reset();
        for (int i = 0; i < 240; i++) begin
            if (i % 60 == 59) do_reset();
            op  = int'($urandom_range(0, 3));
            pin = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 0;
            otp = ($urandom_range(0, 5) == 0) ? 'h1111 : 'h1234;
            sel = int'($urandom_range(0, 3));
            amt = (sel == 0) ? 0 : (sel == 3) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 1500));
            se  = ($urandom_range(0, 7) == 0);
            do_txn("random", op, pin, otp, amt, se);
        end
    endtask

    task automatic test_backpressure();
        int st;
        int n;
        do_reset();
        do_txn("pin_ok6", 0, 0, 0, 0, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b11;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_op = 2'b10; req_amount = 16'd5;
        model_exec(3, 0, 0, 0, 0, st);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            checks += 4;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold rsp_valid: got %0b want 1", rsp_valid); end
            if (rsp_status !== 3'(st)) begin errors++; $display("FAIL hold status: got %0d want %0d", rsp_status, st); end
            if (rsp_balance !== 16'(m_bal)) begin errors++; $display("FAIL hold balance: got %0d want %0d", rsp_balance, m_bal); end
            if (req_ready !== 1'b0) begin errors++; $display("FAIL hold req_ready: got %0b want 0", req_ready); end
            @(negedge clk);
        end
        checks++;
        if (mini_statement !== model_mini()) begin
            errors++;
            $display("FAIL hold mini: got %h want %h", mini_statement, model_mini());
        end
        reset = 1'b1;
        #1;
        checks += 5;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset rsp_valid: got %0b want 0", rsp_valid); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL midreset req_ready: got %0b want 0", req_ready); end
        if (rsp_status !== 3'd0) begin errors++; $display("FAIL midreset status: got %0d want 0", rsp_status); end
        if (rsp_balance !== 16'd0) begin errors++; $display("FAIL midreset balance: got %0d want 0", rsp_balance); end
        if (mini_statement !== 16'd0) begin errors++; $display("FAIL midreset mini: got %h want 0", mini_statement); end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        do_txn("enquiry_after_midreset", 3, 0, 0, 0, 0);
        do_txn("pin_after_midreset", 0, 0, 0, 0, 0);
        do_txn("enquiry_balance_restored", 3, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_withdraw();
        test_block();
        test_deposit();
        test_session_end();
        test_random();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
